// File: rtl/pool_relu_mc.sv
// pool_relu_mc: multi-channel 2x2 stride-2 max/average pooling with optional ReLU.
//   iClk       clock, all logic on the rising edge
//   iRsn       synchronous active-high reset
//   iMode      pooling mode (0 max, 1 average), latched on the first pixel of a frame
//   iInValid   one pixel (all channels) is presented this cycle
//   iPoolData  CH packed signed samples, channel g at [g*DATA_W +: DATA_W]
//   oOutValid  one pooled pixel on oOutData
//   oOutData   CH packed pooled results
//   oFrameDone one-cycle pulse after the last pixel of a frame is accepted
// Build option: define POOL_RELU_EN to clamp negative pooled results to zero.
module pool_relu_mc #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 26,
   parameter int IMG_H  = 26,
   parameter int CH     = 4
) (
   input  logic                 iClk,
   input  logic                 iRsn,
   input  logic                 iMode,
   input  logic                 iInValid,
   input  logic [CH*DATA_W-1:0] iPoolData,
   output logic                 oOutValid,
   output logic [CH*DATA_W-1:0] oOutData,
   output logic                 oFrameDone
);
   localparam int HW = IMG_W / 2;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int IW = HW > 1 ? $clog2(HW) : 1;
   logic [CW-1:0]             r_col;
   logic [RW-1:0]             r_row;
   logic                      r_mode;
   logic [CH*DATA_W-1:0]      r_prev;
   logic signed [DATA_W:0]    r_buf [HW][CH];
   logic                      r_out_valid;
   logic [CH*DATA_W-1:0]      r_out_data;
   logic                      r_frame_done;
   logic [CH*(DATA_W+1)-1:0]  w_pair;
   logic [CH*DATA_W-1:0]      w_res;
   logic                      w_last_col;
   logic                      w_last_row;
   logic                      w_wr;
   logic [IW-1:0]             w_idx;
   assign w_last_col = r_col == CW'(IMG_W - 1);
   assign w_last_row = r_row == RW'(IMG_H - 1);
   // an odd-height frame's trailing top row has no partner row, so it is never stored
   assign w_wr  = r_col[0] && !r_row[0] && !w_last_row;
   assign w_idx = IW'(r_col >> 1);
   genvar g;
   for (g = 0; g < CH; g++) begin : g_ch
      logic signed [DATA_W-1:0] w_cur;
      logic signed [DATA_W-1:0] w_prv;
      logic signed [DATA_W-1:0] w_pmax;
      logic signed [DATA_W-1:0] w_sel;
      logic signed [DATA_W:0]   w_pm1;
      logic signed [DATA_W:0]   w_b;
      logic signed [DATA_W:0]   w_m;
      logic signed [DATA_W+1:0] w_sum;
      assign w_cur  = iPoolData[g*DATA_W +: DATA_W];
      assign w_prv  = r_prev[g*DATA_W +: DATA_W];
      assign w_pmax = w_cur > w_prv ? w_cur : w_prv;
      assign w_pm1  = {w_pmax[DATA_W-1], w_pmax};
      assign w_b    = r_buf[w_idx][g];
      assign w_pair[g*(DATA_W+1) +: DATA_W+1] = r_mode ? {w_cur[DATA_W-1], w_cur} + {w_prv[DATA_W-1], w_prv} : w_pm1;
      assign w_m    = w_b > w_pm1 ? w_b : w_pm1;
      // four-sample sum needs two guard bits; dropping the low two bits is a floor divide by 4
      assign w_sum  = {w_b[DATA_W], w_b} + {{2{w_cur[DATA_W-1]}}, w_cur} + {{2{w_prv[DATA_W-1]}}, w_prv};
      assign w_sel  = r_mode ? w_sum[DATA_W+1:2] : w_m[DATA_W-1:0];
`ifdef POOL_RELU_EN
      assign w_res[g*DATA_W +: DATA_W] = w_sel[DATA_W-1] ? '0 : w_sel;
`else
      assign w_res[g*DATA_W +: DATA_W] = w_sel;
`endif
   end
   always_ff @(posedge iClk) begin
      if (iRsn) begin
         r_col        <= '0;
         r_row        <= '0;
         r_mode       <= 1'b0;
         r_prev       <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < HW; i++)
            for (int j = 0; j < CH; j++)
               r_buf[i][j] <= '0;
      end else begin
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         if (iInValid) begin
            if (r_col == '0 && r_row == '0) r_mode <= iMode;
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
            if (!r_col[0]) r_prev <= iPoolData;
            if (w_wr)
               for (int j = 0; j < CH; j++)
                  r_buf[w_idx][j] <= w_pair[j*(DATA_W+1) +: DATA_W+1];
            if (r_col[0] && r_row[0]) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_res;
            end
            r_frame_done <= w_last_col && w_last_row;
         end
      end
   end
   assign oOutValid  = r_out_valid;
   assign oOutData   = r_out_data;
   assign oFrameDone = r_frame_done;
endmodule

// File: tb/tb_pool_relu_mc.sv
// tb_pool_relu_mc: directed self-checking bench for pool_relu_mc on three frame geometries.
module tb_pool_relu_mc;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   logic v0, m0, ov0, fd0;
   logic [63:0] d0, od0;
   logic v1, m1, ov1, fd1;
   logic [31:0] d1, od1;
   logic v2, m2, ov2, fd2;
   logic [31:0] d2, od2;
   int n_chk = 0;
   int n_fail = 0;
   longint max0 [4] = '{6, 8, 14, 16};
   longint avg0 [4] = '{3, 5, 11, 13};
`ifdef POOL_RELU_EN
   longint max1 [4] = '{0, 0, 0, 0};
   longint avg1 [4] = '{0, 0, 0, 0};
   longint exp1 [2] = '{2, 0};
`else
   longint max1 [4] = '{-1, -3, -9, -11};
   longint avg1 [4] = '{-4, -6, -12, -14};
   longint exp1 [2] = '{2, -5};
`endif
   longint pix1 [8] = '{1, 2, -3, -4, 3, 4, -5, -6};
   longint exp2 [4] = '{6, 8, 16, 18};
   pool_relu_mc #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .CH(2)) u0 (
      .iClk(clk), .iRsn(rst), .iMode(m0), .iInValid(v0), .iPoolData(d0),
      .oOutValid(ov0), .oOutData(od0), .oFrameDone(fd0));
   pool_relu_mc #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .CH(1)) u1 (
      .iClk(clk), .iRsn(rst), .iMode(m1), .iInValid(v1), .iPoolData(d1),
      .oOutValid(ov1), .oOutData(od1), .oFrameDone(fd1));
   pool_relu_mc #(.DATA_W(32), .IMG_W(5), .IMG_H(5), .CH(1)) u2 (
      .iClk(clk), .iRsn(rst), .iMode(m2), .iInValid(v2), .iPoolData(d2),
      .oOutValid(ov2), .oOutData(od2), .oFrameDone(fd2));
   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic px0(input int r, input int c, input bit mode, input bit rs);
      int val;
      val = r * 4 + c + 1;
      v0  = 1'b1;
      m0  = mode;
      d0  = {32'(-val), 32'(val)};
      rst = rs;
      @(posedge clk);
      #1;
      v0  = 1'b0;
      rst = 1'b0;
   endtask
   task automatic chk0(input bit ev, input longint e0, input longint e1, input bit efd);
      check("u0_valid", ov0, ev);
      if (ev) begin
         check("u0_ch0", $signed(od0[31:0]), e0);
         check("u0_ch1", $signed(od0[63:32]), e1);
      end
      check("u0_done", fd0, efd);
   endtask
   task automatic frame0(input bit mode, input bit gaps, input bit flip);
      int k;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (gaps)
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
                  check("gap_valid", ov0, 0);
                  check("gap_done", fd0, 0);
               end
            px0(r, c, (flip && (r > 0 || c > 0)) ? ~mode : mode, 1'b0);
            k = (r / 2) * 2 + c / 2;
            chk0(r % 2 == 1 && c % 2 == 1, mode ? avg0[k] : max0[k], mode ? avg1[k] : max1[k], r == 3 && c == 3);
         end
   endtask
   initial begin
      int n_out;
      rst = 1'b1;
      {v0, m0, v1, m1, v2, m2} = '0;
      d0 = '0;
      d1 = '0;
      d2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid0", ov0, 0);
      check("rst_data0", od0[31:0], 0);
      check("rst_done0", fd0, 0);
      check("rst_valid2", ov2, 0);
      rst = 1'b0;
      frame0(1'b0, 1'b0, 1'b0);
      frame0(1'b0, 1'b1, 1'b0);
      frame0(1'b1, 1'b0, 1'b1);
      frame0(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         px0(i / 4, i % 4, 1'b0, 1'b0);
         chk0(1'b0, 0, 0, 1'b0);
      end
      px0(1, 1, 1'b0, 1'b1);
      check("mid_rst_valid", ov0, 0);
      check("mid_rst_data", od0, 0);
      check("mid_rst_done", fd0, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("post_rst_valid", ov0, 0);
      end
      frame0(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         v1 = 1'b1;
         m1 = 1'b1;
         d1 = 32'(pix1[i]);
         @(posedge clk);
         #1;
         v1 = 1'b0;
         check("u1_valid", ov1, (i / 4 == 1) && (i % 2 == 1));
         if ((i / 4 == 1) && (i % 2 == 1)) check("u1_data", $signed(od1), exp1[(i % 4) / 2]);
         check("u1_done", fd1, i == 7);
      end
      n_out = 0;
      for (int i = 0; i < 25; i++) begin
         v2 = 1'b1;
         m2 = 1'b0;
         d2 = 32'(i);
         @(posedge clk);
         #1;
         v2 = 1'b0;
         check("u2_valid", ov2, ((i / 5) % 2 == 1) && ((i % 5) % 2 == 1));
         if (ov2) begin
            if (n_out < 4) check("u2_data", $signed(od2), exp2[n_out]);
            n_out++;
         end
         check("u2_done", fd2, i == 24);
      end
      check("u2_count", n_out, 4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pool_relu_mc.md
Name: pool_relu_mc

Overview:
- Parametrised successor to the single-channel 2x2 max-pool + ReLU stage in the CNN datapath, placed between the conv accumulator output and the next layer's input buffer.
- Accepts a raster-scan stream of CH parallel channels, one pixel per valid cycle.
- Performs 2x2 stride-2 pooling, selectable max or average, per frame, then applies ReLU.
- Supports arbitrary IMG_W/IMG_H, odd sizes included, and flags end of frame.

Parameters:
- DATA_W, 32, signed sample width per channel.
- IMG_W, 26, input columns per row (>=2).
- IMG_H, 26, input rows per frame (>=2).
- CH, 4, channels processed in parallel; channel c occupies bits [c*DATA_W +: DATA_W].

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRsn  input  1  synchronous, active-high reset.
- iMode  input  1  pooling mode, 0 = max, 1 = average; sampled only on the first pixel of a frame.
- iInValid  input  1  one input pixel (all channels) this cycle.
- iPoolData  input  CH*DATA_W  packed signed input pixels.
- oOutValid  output  1  one pooled pixel on oOutData.
- oOutData  output  CH*DATA_W  packed pooled, ReLU'd results.
- oFrameDone  output  1  single-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0, counters 0, mode latch 0 (max), row buffers cleared. A reset mid-frame discards all partial data; the next valid pixel is row 0, col 0.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on iInValid. Col wraps to 0 and row increments at the end of each row. Row wraps to 0 at the end of the frame. Gaps in iInValid are allowed and state holds across them.
- Mode latch: iMode is captured when iInValid=1 at row 0, col 0 and held for the whole frame. Changing iMode mid-frame has no effect.
- Top rows (even row index, 0-based):
  - On odd col, store per channel a pair value in entry col>>1 of a buffer of IMG_W/2 entries.
  - Pair value in max mode: max(prev, cur).
  - Pair value in avg mode: prev+cur, held at DATA_W+1 bits, sign-extended.
  - Previous-sample register holds the even-col pixel.
- Bottom rows (odd row index), on odd col:
  - Max mode: result = max(buf[col>>1], prev, cur), signed comparison.
  - Avg mode: result = (buf + prev + cur) at DATA_W+2 bits, arithmetic shift right 2 (floor toward -inf), truncated to DATA_W bits; this cannot overflow.
  - Result is registered: oOutValid=1 and oOutData are valid on the cycle after the edge that accepted cur (1-cycle latency).
- Output stream: exactly floor(IMG_W/2) outputs per bottom row, floor(IMG_H/2)*floor(IMG_W/2) per frame.
- Odd IMG_W: the last column is consumed, but nothing is stored and nothing is emitted for it.
- Odd IMG_H: the last row is consumed with no outputs. The buffer is not written on that row.
- oOutValid is deasserted on every cycle that carries no result.
- oFrameDone: asserted for one cycle after the edge that accepts pixel (IMG_H-1, IMG_W-1).
  - If the frame's last output is also produced on that edge, oFrameDone coincides with that oOutValid.
  - The next frame's pixel may be accepted on the very next cycle. Back-to-back frames need no idle cycle, and iMode is re-sampled.
- Channels are fully independent and share the same counters and mode.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: each channel output is ReLU'd after pooling. A negative result (MSB=1) becomes 0; otherwise it passes unchanged. In avg mode the ReLU is applied after the shift.
- Undefined: the signed pooled value is output directly, with no clamp, so the block can feed layers with a separate activation.
- Latency is identical in both builds.

Test Plan:
- Max mode, ReLU on, CH=2, IMG_W=4, IMG_H=4. Ch0 rows are [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16]; ch1 = -ch0. Expect 4 outputs: ch0 = 6, 8, 14, 16; ch1 = 0, 0, 0, 0. oFrameDone fires with the 4th output.
- Avg mode, ReLU off, IMG_W=4, IMG_H=2, CH=1. Rows [1,2,-3,-4] and [3,4,-5,-6]. Expect outputs 2 ((1+2+3+4)>>2 = 2) and -5 (-18>>>2 = -5).
- Odd size, IMG_W=5, IMG_H=5, max mode, pixel value = row*5+col. Expect exactly 4 outputs: 6, 8, 16, 18. oFrameDone pulses after the 25th pixel, with oOutValid=0 on that cycle.
- Gapped input: insert random iInValid=0 bubbles in test 1. Expect identical output values and order, each oOutValid one cycle after its completing pixel.
- Mode latch: start frame with iMode=1, toggle iMode to 0 mid-frame. All outputs of that frame must be averages; the following back-to-back frame with iMode=0 at its first pixel must produce max results.
- Reset mid-frame: pulse iRsn after 6 pixels of test 1, then resend the full frame. Expect no output before the resend, outputs equal to test 1, and all outputs 0 during reset.
